// File: rtl/aq_shift_register.sv
// Joint A:Q register for a restoring divider: load, left-shift, commit/restore, iteration count.
// Latency: each request acts on the edge of its own cycle; one division is 2*WIDTH request cycles after ld.
// Backpressure: none; out-of-phase requests are dropped (and flagged sticky when AQ_SEQ_CHECK_EN is defined).
module aq_shift_register #(
    parameter int  WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] dividend,
    input  logic             shift,
    input  logic             commit,
    input  logic [WIDTH:0]   a_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic             protocol_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        count_d = count_q;
        if (ld) begin
            a_d     = '0;
            q_d     = dividend;
            count_d = CW'(WIDTH);
            state_d = SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (shift) begin
                        {a_d, q_d} = {a_q, q_q} << 1;
                        state_d    = COMMIT;
                    end
                end
                COMMIT: begin
                    if (commit) begin
                        // Sign bit of A - M set means M did not fit: keep A, quotient bit 0.
                        if (!a_in[WIDTH]) begin
                            a_d    = a_in;
                            q_d[0] = 1'b1;
                        end else begin
                            q_d[0] = 1'b0;
                        end
                        count_d = count_q - CW'(1);
                        state_d = (count_q == CW'(1)) ? DONE : SHIFT;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == SHIFT) || (state_d == COMMIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_out = a_q;
    assign q_out = q_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef AQ_SEQ_CHECK_EN
    logic err_q, err_d;
    logic seq_viol;

    always_comb begin
        seq_viol = (shift && commit)
                || (shift  && (state_q != SHIFT))
                || (commit && (state_q != COMMIT));
        err_d    = ld ? 1'b0 : (err_q || seq_viol);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign protocol_err = err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_aq_shift_register.sv
// Randomized and directed bench for aq_shift_register against a transaction-level division model.
`timescale 1ns/1ps
module tb_aq_shift_register;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, ld, shift, commit;
    logic [W-1:0]  dividend;
    logic [W:0]    a_in, a_out;
    logic [W-1:0]  q_out;
    logic [CW-1:0] count;
    logic          busy, done, protocol_err;

    logic [7:0] dividend8;
    logic [8:0] a_in8, a_out8;
    logic [7:0] q_out8;
    logic [3:0] count8;
    logic       busy8, done8, perr8;
    logic [7:0] m8;

    always #5 clk = ~clk;

    aq_shift_register #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ld(ld), .dividend(dividend), .shift(shift), .commit(commit),
        .a_in(a_in), .a_out(a_out), .q_out(q_out), .count(count), .busy(busy), .done(done),
        .protocol_err(protocol_err)
    );

    // Wide instance shares the control strobes; its subtractor is modelled combinationally.
    assign a_in8 = a_out8 - {1'b0, m8};
    aq_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ld(ld), .dividend(dividend8), .shift(shift), .commit(commit),
        .a_in(a_in8), .a_out(a_out8), .q_out(q_out8), .count(count8), .busy(busy8), .done(done8),
        .protocol_err(perr8)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {A,Q} as one number plus a count of remaining requests (2*W per division).
    logic [W:0]   a_m;
    logic [W-1:0] q_m;
    int           steps_m;
    bit           act_m, done_m, err_m;
    logic [W-1:0] dvd_m, m_m, m_cur;

    task automatic cyc(input bit l, input bit s, input bit c, input bit r);
        bit viol, was_done;
        ld = l; shift = s; commit = c; rst = r;
        a_in = a_m - {1'b0, m_cur};
        was_done = done_m;
        if (r) begin
            a_m = '0; q_m = '0; steps_m = 0; act_m = 0; done_m = 0; err_m = 0;
        end else if (l) begin
            a_m = '0; q_m = dividend; steps_m = 2 * W; act_m = 1; done_m = 0; err_m = 0;
            dvd_m = dividend; m_m = m_cur;
        end else begin
            viol = (s && c) || (s && !(act_m && steps_m % 2 == 0))
                 || (c && !(act_m && steps_m % 2 == 1));
            if (c && act_m && steps_m % 2 == 1) begin
                if (a_in[W] == 1'b0) begin
                    a_m = a_in; q_m = q_m | W'(1);
                end else begin
                    q_m = q_m & ~W'(1);
                end
                steps_m--;
                if (steps_m == 0) begin act_m = 0; done_m = 1; end
            end else if (s && act_m && steps_m % 2 == 0) begin
                {a_m, q_m} = {a_m, q_m} << 1;
                steps_m--;
            end
            err_m = err_m | viol;
        end
        @(posedge clk);
        #1;
        chk("a_out", 32'(a_out), 32'(a_m));
        chk("q_out", 32'(q_out), 32'(q_m));
        chk("count", 32'(count), 32'((steps_m + 1) / 2));
        chk("busy", 32'(busy), 32'(act_m));
        chk("done", 32'(done), 32'(done_m));
`ifdef AQ_SEQ_CHECK_EN
        chk("protocol_err", 32'(protocol_err), 32'(err_m));
`else
        chk("protocol_err", 32'(protocol_err), 32'(0));
`endif
        if (done_m && !was_done) begin
            if (m_m == 0) begin
                chk("div0_quot", 32'(q_out), 32'((1 << W) - 1));
                chk("div0_rem", 32'(a_out), 32'(dvd_m));
            end else begin
                chk("quot", 32'(q_out), 32'(dvd_m / m_m));
                chk("rem", 32'(a_out), 32'(dvd_m % m_m));
            end
        end
    endtask

    task automatic do_ld(input logic [W-1:0] dvd, input logic [W-1:0] m);
        dividend = dvd; m_cur = m;
        cyc(1, 0, 0, 0);
    endtask

    task automatic pairs(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 1, 0);
        end
    endtask

    initial begin
        rst = 1; ld = 0; shift = 0; commit = 0; dividend = '0; a_in = '0;
        dividend8 = '0; m8 = '0; m_cur = '0; dvd_m = '0; m_m = '0;
        a_m = '0; q_m = '0; steps_m = 0; act_m = 0; done_m = 0; err_m = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // Basic divisions, explicit results on top of the model checks.
        do_ld(7, 2); pairs(W);
        chk("q_7_2", 32'(q_out), 3); chk("a_7_2", 32'(a_out), 1);
        chk("done_7_2", 32'(done), 1); chk("cnt_7_2", 32'(count), 0);
        do_ld(13, 3); pairs(W);
        chk("q_13_3", 32'(q_out), 4); chk("a_13_3", 32'(a_out), 1);

        // Wide instance: 200 / 7.
        dividend8 = 8'd200; m8 = 8'd7;
        do_ld(1, 1); pairs(8);
        chk("q8_200_7", 32'(q_out8), 28); chk("a8_200_7", 32'(a_out8), 4);
        chk("done8", 32'(done8), 1);

        // Reset mid-run after the second commit, then a clean run.
        do_ld(7, 2); pairs(2);
        cyc(0, 0, 0, 1);
        chk("rst_busy", 32'(busy), 0); chk("rst_q", 32'(q_out), 0);
        do_ld(7, 2); pairs(W);
        chk("q_after_rst", 32'(q_out), 3);

        // Restart with ld while busy at count=2.
        do_ld(11, 3); pairs(2);
        chk("cnt_mid", 32'(count), 2);
        do_ld(9, 2);
        chk("reld_cnt", 32'(count), W); chk("reld_q", 32'(q_out), 9); chk("reld_a", 32'(a_out), 0);
        pairs(W);
        chk("q_9_2", 32'(q_out), 4); chk("a_9_2", 32'(a_out), 1);

        // Out-of-phase requests: ignored, optionally flagged until ld.
        do_ld(7, 2);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        pairs(W - 1);
        cyc(0, 1, 1, 0);
        chk("done_hold_q", 32'(q_out), 3);
        cyc(0, 0, 0, 0);
        do_ld(3, 1);

        // Divide by zero yields all-ones quotient.
        do_ld(5, 0); pairs(W);
        chk("q_div0", 32'(q_out), 15); chk("a_div0", 32'(a_out), 5);

        // Random traffic, mostly in-phase requests.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
            else if (r < 8) do_ld(W'($urandom), W'($urandom));
            else if (r < 88 && act_m) cyc(0, steps_m % 2 == 0, steps_m % 2 == 1, 0);
            else cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
